// File: rtl/mdu_pkg.sv
// Shared MDU op/state encodings and op classification helpers.
// Optional MADD/MSUB support is enabled by defining MDU_SCHED_MADD_EN.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MSUB  = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for MUL_LAT/DIV_LAT cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_SCHED_MADD_EN
      OP_MADD, OP_MSUB: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_DIV, OP_DIVU: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_sched_calc.sv
// Combinational 64-bit MDU result: {pend_hi,pend_lo} for the op being launched.
// MADD/MSUB accumulate paths exist only when MDU_SCHED_MADD_EN is defined.
module mdu_sched_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] pend_hi_o,
  output logic [31:0] pend_lo_o
);

  logic [63:0] sprod_s;
  logic [63:0] uprod_s;
  logic [63:0] res_s;
  logic [31:0] rt_safe_s;
  logic [31:0] rs_abs_s;
  logic [31:0] rt_abs_s;
  logic [31:0] mq_s;
  logic [31:0] mr_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] sq_s;
  logic [31:0] sr_s;
  logic        div_zero_s;

  // Products and quotients for both signednesses.
  always_comb begin
    sprod_s    = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    uprod_s    = {32'd0, rs_i} * {32'd0, rt_i};
    div_zero_s = (rt_i == 32'd0);
    rt_safe_s  = div_zero_s ? 32'd1 : rt_i;
    rs_abs_s   = rs_i[31] ? (32'd0 - rs_i) : rs_i;
    rt_abs_s   = rt_safe_s[31] ? (32'd0 - rt_safe_s) : rt_safe_s;
    uq_s       = rs_i / rt_safe_s;
    ur_s       = rs_i % rt_safe_s;
    // Magnitude divide, then restore signs: quotient truncates, remainder follows dividend.
    mq_s       = rs_abs_s / rt_abs_s;
    mr_s       = rs_abs_s % rt_abs_s;
    sq_s       = (rs_i[31] ^ rt_i[31]) ? (32'd0 - mq_s) : mq_s;
    sr_s       = rs_i[31] ? (32'd0 - mr_s) : mr_s;
  end

  // Select the result; divide by zero leaves HI/LO as they are.
  always_comb begin
    res_s = {hi_i, lo_i};
    case (op_i)
      OP_MULT:  res_s = sprod_s;
      OP_MULTU: res_s = uprod_s;
      OP_DIV: begin
        if (div_zero_s) begin
          res_s = {hi_i, lo_i};
        end else begin
          res_s = {sr_s, sq_s};
        end
      end
      OP_DIVU: begin
        if (div_zero_s) begin
          res_s = {hi_i, lo_i};
        end else begin
          res_s = {ur_s, uq_s};
        end
      end
`ifdef MDU_SCHED_MADD_EN
      OP_MADD:  res_s = {hi_i, lo_i} + sprod_s;
      OP_MSUB:  res_s = {hi_i, lo_i} - sprod_s;
`endif
      default:  res_s = {hi_i, lo_i};
    endcase
  end

  assign pend_hi_o = res_s[63:32];
  assign pend_lo_o = res_s[31:0];

endmodule

// File: rtl/mdu_sched.sv
// MDU scheduler for the E stage: runs long mult/div ops, owns HI/LO, drives mduo and stall.
// Defining MDU_SCHED_MADD_EN enables the MADD/MSUB accumulate ops.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_mdu_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mduo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0]      calc_hi_s, calc_lo_s;
  logic             idle_s, launch_s, finish_s;
  logic             busy_s, stall_s;
  logic [31:0]      mduo_s;

  assign idle_s   = (state_q == ST_IDLE);
  assign launch_s = start & idle_s & is_long_op(op);
  assign finish_s = (state_q == ST_RUN) & (cnt_q == CNT_ONE);

  mdu_sched_calc u_calc (
    .op_i      (op),
    .rs_i      (rs_val),
    .rt_i      (rt_val),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .pend_hi_o (calc_hi_s),
    .pend_lo_o (calc_lo_s)
  );

  // State, counter and architectural/pending registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // Next state and latency countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_s) begin
          state_d = ST_RUN;
          cnt_d   = is_div_op(op) ? DIV_CNT : MUL_CNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // HI/LO and pending-result updates; starts are only honoured in IDLE.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (launch_s) begin
      pend_hi_d = calc_hi_s;
      pend_lo_d = calc_lo_s;
    end else if (finish_s) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end else if (start && idle_s && (op == OP_MTHI)) begin
      hi_d = rs_val;
    end else if (start && idle_s && (op == OP_MTLO)) begin
      lo_d = rs_val;
    end else begin
      hi_d = hi_q;
    end
  end

  // Outputs.
  always_comb begin
    busy_s  = (state_q == ST_RUN);
    stall_s = d_mdu_use & (busy_s | (start & is_long_op(op)));
    case (op)
      OP_MFHI: mduo_s = hi_q;
      OP_MFLO: mduo_s = lo_q;
      default: mduo_s = 32'd0;
    endcase
  end

  assign busy  = busy_s;
  assign stall = stall_s;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mduo  = mduo_s;

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized self-checking bench for mdu_sched against an arithmetic reference model.
module tb_mdu_sched;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;
  localparam logic [3:0] MADD = 4'd9, MSUB = 4'd10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_mdu_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mduo;

  int n_checks;
  int n_errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_mdu_use (d_mdu_use),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .mduo      (mduo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_long(input logic [3:0] o);
`ifdef MDU_SCHED_MADD_EN
    return (o >= MULT && o <= DIVU) || o == MADD || o == MSUB;
`else
    return (o >= MULT && o <= DIVU);
`endif
  endfunction

  function automatic int model_lat(input logic [3:0] o);
    return (o == DIV || o == DIVU) ? int'(DIV_LAT) : int'(MUL_LAT);
  endfunction

  // Reference arithmetic on 64-bit integers.
  function automatic logic [63:0] model_result(input logic [3:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
    int sa, sb;
    longint la, lb, q, r;
    longint unsigned ua, ub;
    logic [63:0] res;
    sa = a; sb = b; la = sa; lb = sb; ua = a; ub = b;
    res = {h, l};
    case (o)
      MULT:  res = la * lb;
      MULTU: res = ua * ub;
      DIV: if (b != 32'd0) begin
        q = la / lb; r = la % lb;
        res = {r[31:0], q[31:0]};
      end
      DIVU: if (b != 32'd0) begin
        q = longint'(ua / ub); r = longint'(ua % ub);
        res = {r[31:0], q[31:0]};
      end
`ifdef MDU_SCHED_MADD_EN
      MADD:  res = {h, l} + 64'(la * lb);
      MSUB:  res = {h, l} - 64'(la * lb);
`endif
      default: res = {h, l};
    endcase
    return res;
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic dmu);
    bit lng;
    int lat;
    logic [63:0] res;
    logic [31:0] exp_hi, exp_lo;
    lng = model_long(o);
    lat = model_lat(o);
    exp_hi = m_hi;
    exp_lo = m_lo;
    if (lng) begin
      res = model_result(o, a, b, m_hi, m_lo);
      exp_hi = res[63:32];
      exp_lo = res[31:0];
    end else if (o == MTHI) begin
      exp_hi = a;
    end else if (o == MTLO) begin
      exp_lo = a;
    end
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; d_mdu_use = dmu;
    #1;
    check_eq("stall_start", 32'(stall), 32'(dmu & lng));
    check_eq("busy_pre", 32'(busy), 32'd0);
    check_eq("mduo_start", mduo, (o == MFHI) ? m_hi : ((o == MFLO) ? m_lo : 32'd0));
    @(negedge clk);
    start = 1'b0; op = NOP; rs_val = $urandom; rt_val = $urandom;
    #1;
    if (lng) begin
      for (int i = 0; i < lat; i++) begin
        check_eq("busy_run", 32'(busy), 32'd1);
        check_eq("stall_run", 32'(stall), 32'(dmu));
        check_eq("hi_hold", hi, m_hi);
        check_eq("lo_hold", lo, m_lo);
        @(negedge clk);
        #1;
      end
    end
    check_eq("busy_done", 32'(busy), 32'd0);
    check_eq("stall_done", 32'(stall), 32'd0);
    check_eq("hi_result", hi, exp_hi);
    check_eq("lo_result", lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
    op = MFLO;
    #1;
    check_eq("mduo_mflo", mduo, m_lo);
    op = MFHI;
    #1;
    check_eq("mduo_mfhi", mduo, m_hi);
    op = NOP;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0; n_errors = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b0; start = 1'b0; op = NOP; rs_val = 32'd0; rt_val = 32'd0; d_mdu_use = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    reset = 1'b1;

    do_op(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check_eq("t1_hi", hi, 32'hFFFF_FFFF);
    check_eq("t1_lo", lo, 32'hFFFF_FFFA);

    do_op(DIVU, 32'd100, 32'd7, 1'b0);
    check_eq("t2_divu_lo", lo, 32'd14);
    check_eq("t2_divu_hi", hi, 32'd2);
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("t2_div_lo", lo, 32'hFFFF_FFFD);
    check_eq("t2_div_hi", hi, 32'hFFFF_FFFF);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1; op = MTHI; rs_val = 32'h1234_5678; d_mdu_use = 1'b0;
    @(negedge clk);
    op = MTLO; rs_val = 32'hCAFE_0000;
    #1;
    check_eq("t3_hi", hi, 32'h1234_5678);
    check_eq("t3_busy1", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0; op = NOP;
    #1;
    check_eq("t3_lo", lo, 32'hCAFE_0000);
    check_eq("t3_busy2", 32'(busy), 32'd0);
    m_hi = 32'h1234_5678; m_lo = 32'hCAFE_0000;

    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("ovf_lo", lo, 32'h8000_0000);
    check_eq("ovf_hi", hi, 32'd0);

    do_op(DIV, 32'd1000, 32'd10, 1'b1);
    check_eq("t4_quot", lo, 32'd100);

    do_op(MTHI, 32'hA, 32'd0, 1'b0);
    do_op(MTLO, 32'hB, 32'd0, 1'b0);
    do_op(DIV, 32'd5, 32'd0, 1'b0);
    check_eq("t5_hi", hi, 32'hA);
    check_eq("t5_lo", lo, 32'hB);

    // Reset pulse in the third busy cycle of a MULT
    @(negedge clk);
    start = 1'b1; op = MULT; rs_val = 32'd7; rt_val = 32'd9; d_mdu_use = 1'b0;
    @(negedge clk);
    start = 1'b0; op = NOP;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rstmid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_hi", hi, 32'd0);
    check_eq("rstmid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (MUL_LAT + 1) @(negedge clk);
    #1;
    check_eq("rstmid_hi_after", hi, 32'd0);
    check_eq("rstmid_lo_after", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    do_op(MTHI, 32'd0, 32'd0, 1'b0);
    do_op(MTLO, 32'd5, 32'd0, 1'b0);
    do_op(MADD, 32'd2, 32'd3, 1'b1);
    check_eq("t6_hi", hi, 32'd0);
`ifdef MDU_SCHED_MADD_EN
    check_eq("t6_lo", lo, 32'd11);
`else
    check_eq("t6_lo", lo, 32'd5);
`endif

    for (int k = 0; k < 150; k++) begin
      do_op(4'($urandom_range(0, 10)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
